// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader (write side of the 32-bit program memory).
//
// A load is a count byte (number of words, 0 means 256) followed by four
// bytes per word, most significant byte first. Each assembled word is
// written to sequential program memory addresses starting at BASE_ADDR.
// The processor is held off for the whole load.
//
// Optional feature macro: LOADER_CHKSUM_EN
//   When defined, one trailing checksum byte is accepted after the last
//   word. The mod-256 sum of the count byte, all data bytes and the
//   checksum byte must be zero, otherwise error is raised alongside done.
//   When undefined there is no CHECK state and error is tied low.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     synchronous active-low reset
//   start       single-cycle load request, honoured in IDLE or DONE only
//   byte_in     stream byte
//   byte_valid  byte_in valid this cycle
//   byte_ready  loader accepts a byte this cycle (transfer = valid && ready)
//   pm_we       program memory write strobe, one cycle per word
//   pm_addr     program memory write address
//   pm_wdata    assembled instruction word
//   cpu_hold    high while a load is in progress
//   done        load completed; held until the next accepted start
//   error       checksum mismatch; held like done
module prog_loader #(
    parameter int          ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              pm_we,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [31:0]       pm_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_WRITE,
`ifdef LOADER_CHKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  byte_cnt;   // byte position within the current word
    logic [8:0]  word_cnt;   // words still to be written (1..256)
    logic        xfer;

    assign xfer = byte_valid && byte_ready;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_COUNT;
            S_COUNT:        if (xfer) state_nx = S_DATA;
            S_DATA:         if (xfer && byte_cnt == 2'd3) state_nx = S_WRITE;
            S_WRITE: begin
                if (word_cnt == 9'd1) begin
`ifdef LOADER_CHKSUM_EN
                    state_nx = S_CHECK;
`else
                    state_nx = S_DONE;
`endif
                end else begin
                    state_nx = S_DATA;
                end
            end
`ifdef LOADER_CHKSUM_EN
            S_CHECK:        if (xfer) state_nx = S_DONE;
`endif
            default:        state_nx = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        byte_ready = 1'b0;
        pm_we      = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        case (state)
            S_COUNT, S_DATA: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
            end
            S_WRITE: begin
                pm_we    = 1'b1;
                cpu_hold = 1'b1;
            end
`ifdef LOADER_CHKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
            end
`endif
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: address, word assembly and counters
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pm_addr  <= BASE;
            pm_wdata <= 32'd0;
            byte_cnt <= 2'd0;
            word_cnt <= 9'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pm_addr  <= BASE;
                        byte_cnt <= 2'd0;
                    end
                end
                S_COUNT: begin
                    // A count byte of zero encodes a full 256-word image.
                    if (xfer) word_cnt <= (byte_in == 8'd0) ? 9'd256 : {1'b0, byte_in};
                end
                S_DATA: begin
                    // Shifting left places the first byte in [31:24] after four bytes.
                    if (xfer) begin
                        pm_wdata <= {pm_wdata[23:0], byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                S_WRITE: begin
                    pm_addr  <= pm_addr + ADDR_W'(1);
                    word_cnt <= word_cnt - 9'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHKSUM_EN
    logic [7:0] chksum;
    logic       err_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            chksum <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        chksum <= 8'd0;
                        err_q  <= 1'b0;
                    end
                end
                S_COUNT, S_DATA: if (xfer) chksum <= chksum + byte_in;
                S_CHECK:         if (xfer) err_q <= (8'(chksum + byte_in) != 8'd0);
                default: ;
            endcase
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader. Two instances (BASE_ADDR 0
// and 8) share one stimulus stream; the expected writes and completion
// results are derived from the word list of each load and queued, and a
// monitor per instance pops and compares on every write strobe and on the
// rising edge of done.
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'd0;

    logic        br0, we0, hold0, done0, err0;
    logic [7:0]  addr0;
    logic [31:0] wd0;
    logic        br8, we8, hold8, done8, err8;
    logic [7:0]  addr8;
    logic [31:0] wd8;

    always #5 clock = ~clock;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(br0), .pm_we(we0), .pm_addr(addr0),
        .pm_wdata(wd0), .cpu_hold(hold0), .done(done0), .error(err0));

    prog_loader #(.ADDR_W(8), .BASE_ADDR(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(br8), .pm_we(we8), .pm_addr(addr8),
        .pm_wdata(wd8), .cpu_hold(hold8), .done(done8), .error(err8));

    typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic [7:0] addr; logic err; } fin_t;

    wr_t  wq0[$], wq8[$];
    fin_t fq0[$], fq8[$];
    wr_t  e0, e8;
    fin_t f0, f8;
    logic pdone0 = 1'b0, pdone8 = 1'b0, pwe0 = 1'b0, pwe8 = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    // Monitor for the BASE_ADDR=0 instance
    always @(negedge clock) begin
        if (we0) begin
            chk("dut0 byte_ready during write", br0, 0);
            if (wq0.size() == 0) fail_now("dut0 unexpected write");
            else begin
                e0 = wq0.pop_front();
                chk("dut0 pm_addr", addr0, e0.addr);
                chk("dut0 pm_wdata", wd0, e0.data);
            end
        end
        if (done0 && !pdone0) begin
            if (fq0.size() == 0) fail_now("dut0 unexpected done");
            else begin
                f0 = fq0.pop_front();
                chk("dut0 final pm_addr", addr0, f0.addr);
                chk("dut0 error", err0, f0.err);
                chk("dut0 cpu_hold at done", hold0, 0);
                chk("dut0 byte_ready at done", br0, 0);
`ifndef LOADER_CHKSUM_EN
                chk("dut0 done follows write", pwe0, 1);
`endif
            end
        end
        pdone0 <= done0;
        pwe0   <= we0;
    end

    // Monitor for the BASE_ADDR=8 instance
    always @(negedge clock) begin
        if (we8) begin
            chk("dut8 byte_ready during write", br8, 0);
            if (wq8.size() == 0) fail_now("dut8 unexpected write");
            else begin
                e8 = wq8.pop_front();
                chk("dut8 pm_addr", addr8, e8.addr);
                chk("dut8 pm_wdata", wd8, e8.data);
            end
        end
        if (done8 && !pdone8) begin
            if (fq8.size() == 0) fail_now("dut8 unexpected done");
            else begin
                f8 = fq8.pop_front();
                chk("dut8 final pm_addr", addr8, f8.addr);
                chk("dut8 error", err8, f8.err);
                chk("dut8 cpu_hold at done", hold8, 0);
            end
        end
        pdone8 <= done8;
        pwe8   <= we8;
    end

    task automatic chk_reset_state();
        chk("rst byte_ready", {br8, br0}, 0);
        chk("rst pm_we", {we8, we0}, 0);
        chk("rst dut0 pm_addr", addr0, 8'd0);
        chk("rst dut8 pm_addr", addr8, 8'd8);
        chk("rst pm_wdata", wd0 | wd8, 0);
        chk("rst cpu_hold", {hold8, hold0}, 0);
        chk("rst done", {done8, done0}, 0);
        chk("rst error", {err8, err0}, 0);
    endtask

    // One load: n words (256 encoded as count 0). mode 0 back-to-back,
    // 1 one idle cycle before every byte, 2 random gaps. noise drives
    // random start pulses while the load is in progress. abort_at >= 0
    // resets after that many data bytes have been accepted.
    task automatic load(input int n, input int mode, input bit noise, input int abort_at,
                        input bit use_w0, input logic [31:0] w0);
        logic [7:0]  bytes[$];
        logic [31:0] w;
        logic [7:0]  sum;
        logic        bad;
        int          t;
        bit          rdy;
        bad = 1'b0;
        bytes.push_back(8'(n));
        sum = 8'(n);
        for (int i = 0; i < n; i++) begin
            w = (i == 0 && use_w0) ? w0 : $urandom;
            if (abort_at < 0 || (i + 1) * 4 <= abort_at) begin
                wq0.push_back(wr_t'{8'(i), w});
                wq8.push_back(wr_t'{8'(8 + i), w});
            end
            for (int k = 3; k >= 0; k--) begin
                bytes.push_back(w[k*8 +: 8]);
                sum = sum + w[k*8 +: 8];
            end
        end
`ifdef LOADER_CHKSUM_EN
        bad = 1'($urandom_range(0, 1));
        bytes.push_back(8'(8'd0 - sum) + (bad ? 8'd1 : 8'd0));
`endif
        if (abort_at < 0) begin
            fq0.push_back(fin_t'{8'(n), bad});
            fq8.push_back(fin_t'{8'(8 + n), bad});
        end

        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
        for (int idx = 0; idx < bytes.size(); idx++) begin
            if (abort_at >= 0 && idx == 1 + abort_at) begin
                reset_n = 1'b0;
                byte_valid = 1'b0;
                @(negedge clock);
                chk_reset_state();
                reset_n = 1'b1;
                return;
            end
            if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                byte_valid = 1'b0;
                byte_in = 8'($urandom);
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clock);
            end
            byte_valid = 1'b1;
            byte_in = bytes[idx];
            t = 0;
            forever begin
                start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                rdy = br0;
                @(negedge clock);
                if (rdy) break;
                if (++t > 20) begin
                    fail_now("byte_ready timeout");
                    break;
                end
            end
        end
        byte_valid = 1'b0;
        start = 1'b0;
        t = 0;
        while (!done0 && t < 30) begin
            @(negedge clock);
            t++;
        end
        if (!done0) fail_now("done timeout");
        @(negedge clock);
        chk("dut0 done held", done0, 1);
        chk("dut0 writes outstanding", wq0.size(), 0);
        chk("dut8 writes outstanding", wq8.size(), 0);
        chk("completions outstanding", fq0.size() + fq8.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_reset_state();
        reset_n = 1'b1;
        @(negedge clock);

        load(1, 0, 1'b0, -1, 1'b1, 32'h0000_9802);   // single word
        load(3, 1, 1'b0, -1, 1'b0, 32'd0);            // stalls every other cycle
        load(256, 0, 1'b0, -1, 1'b0, 32'd0);          // count 0, address wrap
        load(2, 0, 1'b0, 6, 1'b0, 32'd0);             // reset mid word 1
        load(1, 0, 1'b0, -1, 1'b0, 32'd0);            // fresh load after reset
        load(3, 2, 1'b1, -1, 1'b0, 32'd0);            // start noise mid-load
        for (int r = 0; r < 8; r++)
            load($urandom_range(1, 5), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 -1, 1'b0, 32'd0);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

endmodule
